serial_adder: RTL and testbench

Bit-serial two's-complement adder for the datapath. It accepts two WIDTH-bit operands and a carry-in on a start pulse and adds them LSB-first, one bit per clock, through a single full-adder cell. It reports sum, carry-out and signed overflow with a one-cycle done strobe. It is the addition counterpart to the borrow-chain subtract cell, and is used where area matters more than latency.

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/serial_adder_full_adder_1bit.sv | 20 ++
 rtl/serial_adder.sv | 103 ++++++++++
 tb/tb_serial_adder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and counter sizing.
// Imported by the serial adder top and its full-adder cell.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   // Bit counter width; counts 0..WIDTH-1.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_full_adder_1bit.sv
// Gate-level single-bit full adder; the addition mirror of the borrow-chain subtract cell.
module full_adder_1bit (
   input  logic A,
   input  logic B,
   input  logic Cin,
   output logic out,
   output logic Cout
);

   logic ab_x;
   logic ab_a;
   logic xc_a;

   xor g_x0 (ab_x, A, B);
   xor g_x1 (out, ab_x, Cin);
   and g_a0 (ab_a, A, B);
   and g_a1 (xc_a, ab_x, Cin);
   or  g_o0 (Cout, ab_a, xc_a);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder: one full-adder cell, LSB-first, WIDTH+1 cycle latency.
// start is accepted only in IDLE or DONE (a start while RUN is high is dropped); done pulses one cycle.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic [1:0]       state_dbg
);

   localparam int CNT_W = cnt_width(WIDTH);

   state_t             state;
   state_t             state_nx;
   logic [WIDTH-1:0]   a_sh;
   logic [WIDTH-1:0]   b_sh;
   logic [WIDTH-1:0]   s_sh;
   logic [CNT_W-1:0]   cnt;
   logic               carry;
   logic               carry_msb;
   logic               fa_s;
   logic               fa_c;
   logic               load;
   logic               last_bit;

   full_adder_1bit u_fa (
      .A    (a_sh[0]),
      .B    (b_sh[0]),
      .Cin  (carry),
      .out  (fa_s),
      .Cout (fa_c)
   );

   assign load     = start && (state == IDLE || state == DONE);
   assign last_bit = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last_bit) state_nx = DONE;
         DONE:    state_nx = start ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state == RUN);
      done      = (state == DONE);
      state_dbg = state;
   end

   // Datapath: operand shifters, partial sum, bit counter and the held result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_sh      <= '0;
         b_sh      <= '0;
         s_sh      <= '0;
         cnt       <= '0;
         carry     <= 1'b0;
         carry_msb <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         overflow  <= 1'b0;
      end else if (load) begin
         a_sh      <= a;
         b_sh      <= b;
         s_sh      <= '0;
         cnt       <= '0;
         carry     <= cin;
         carry_msb <= 1'b0;
      end else if (state == RUN) begin
         a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
         b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
         s_sh  <= {fa_s, s_sh[WIDTH-1:1]};
         carry <= fa_c;
         cnt   <= cnt + 1'b1;
         if (cnt == CNT_W'(WIDTH - 2)) carry_msb <= fa_c;
         if (last_bit) begin
            sum      <= {fa_s, s_sh[WIDTH-1:1]};
            cout     <= fa_c;
            overflow <= carry_msb ^ fa_c;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized bench for serial_adder with a result scoreboard.
module tb_serial_adder;
   import serial_adder_pkg::*;

   localparam int WIDTH = 8;
   localparam int BUDGET = 50;

   logic             clk;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;
   logic [1:0]       state_dbg;

   logic [WIDTH+1:0] exp_q[$];
   int               checks;
   int               errors;

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .cout      (cout),
      .overflow  (overflow),
      .state_dbg (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {overflow, cout, sum} from a full-width add and operand sign rule.
   function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic ci);
      logic [WIDTH:0]   full;
      logic [WIDTH-1:0] s;
      logic             v;
      full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
      s    = full[WIDTH-1:0];
      v    = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
      return {v, full[WIDTH], s};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives operands at a falling edge so the next rising edge accepts them.
   task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
      @(negedge clk);
      a = x; b = y; cin = ci; start = 1'b1;
      exp_q.push_back(model(x, y, ci));
   endtask

   // Waits for done; k-th falling edge after the accepting edge is cycle k.
   task automatic wait_done(input bit hold, input int glitch_at,
                            output int lat, output int busy_cnt);
      lat = 0;
      busy_cnt = 0;
      for (int k = 1; k <= BUDGET; k++) begin
         @(negedge clk);
         if (!hold && k == 1) start = 1'b0;
         if (k == glitch_at) begin
            start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
         end
         if (glitch_at > 0 && k == glitch_at + 1) start = 1'b0;
         if (busy) busy_cnt++;
         if (done) begin
            lat = k;
            break;
         end
      end
      if (lat == 0) check("done_timeout", done, 1);
   endtask

   task automatic check_result(input string tag);
      logic [WIDTH+1:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_queue_empty"}, exp_q.size(), 1);
         return;
      end
      e = exp_q.pop_front();
      check({tag, "_sum"}, sum, e[WIDTH-1:0]);
      check({tag, "_cout"}, cout, e[WIDTH]);
      check({tag, "_ovf"}, overflow, e[WIDTH+1]);
   endtask

   task automatic single(input string tag, input logic [WIDTH-1:0] x,
                         input logic [WIDTH-1:0] y, input logic ci);
      int lat;
      int bc;
      start_op(x, y, ci);
      wait_done(1'b0, 0, lat, bc);
      check({tag, "_latency"}, lat, WIDTH + 1);
      check({tag, "_busy_cycles"}, bc, WIDTH);
      check_result(tag);
   endtask

   initial begin
      int lat;
      int bc;
      checks = 0;
      errors = 0;
      reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_state", state_dbg, IDLE);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", overflow, 0);
      reset = 1'b0;

      single("basic", 8'h3C, 8'h42, 1'b0);
      @(negedge clk);
      check("held_sum", sum, 8'h7E);
      check("idle_state", state_dbg, IDLE);
      single("wrap", 8'hFF, 8'h01, 1'b0);
      single("pos_ovf", 8'h7F, 8'h01, 1'b0);
      single("all_ones_cin", 8'hFF, 8'hFF, 1'b1);
      single("neg_ovf", 8'h80, 8'h80, 1'b0);

      // start re-asserted mid-RUN is ignored.
      start_op(8'h12, 8'h34, 1'b0);
      wait_done(1'b0, 3, lat, bc);
      check("ignore_latency", lat, WIDTH + 1);
      check_result("ignore");
      @(negedge clk);
      check("ignore_done_once", done, 0);
      check("ignore_idle", state_dbg, IDLE);

      // Reset mid-RUN abandons the operation and clears outputs at once.
      single("pre_reset", 8'h3C, 8'h42, 1'b0);
      start_op(8'h55, 8'h11, 1'b0);
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid_rst_sum", sum, 0);
      check("mid_rst_cout", cout, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_state", state_dbg, IDLE);
      void'(exp_q.pop_back());
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_idle", state_dbg, IDLE);
      single("after_reset", 8'h10, 8'h20, 1'b0);

      // Back-to-back with start held; new operands presented in each DONE cycle.
      start_op(8'h3C, 8'h42, 1'b0);
      for (int i = 0; i < 1000; i++) begin
         wait_done(1'b1, 0, lat, bc);
         check("b2b_latency", lat, WIDTH + 1);
         check_result("b2b");
         if (i < 999) begin
            a = WIDTH'($urandom_range(0, 255));
            b = WIDTH'($urandom_range(0, 255));
            cin = 1'($urandom_range(0, 1));
            exp_q.push_back(model(a, b, cin));
         end else begin
            start = 1'b0;
         end
      end
      @(negedge clk);
      check("b2b_end_idle", state_dbg, IDLE);
      check("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
